// File: rtl/serial_to_parallel_stream.sv
// Valid/ready deserializer: packs in_width-bit beats into in_width*beats-bit words.
// Optional partial-word flush is compiled in with SERIAL_TO_PARALLEL_STREAM_FLUSH_EN.
module serial_to_parallel_stream #(
  parameter int in_width  = 1,
  parameter int beats     = 8,
  parameter bit msb_first = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [in_width-1:0]          in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [in_width*beats-1:0]    out_data,
  output logic [$clog2(beats+1)-1:0]   out_beats
);

  localparam int W  = in_width * beats;
  localparam int CW = $clog2(beats);
  localparam int BW = $clog2(beats + 1);
  localparam logic [CW-1:0] LAST = CW'(beats - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] slot;
  logic [W-1:0]  acc;
  logic [W-1:0]  merged;
  logic          slot_free;
  logic          is_final;
  logic          accept;
  logic          flush_active;
  logic          load_full;
  logic          load_flush;

`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
  logic          flush_req;
  logic [BW-1:0] beats_q;

  // flush_req looks only at in_valid (not at acceptance) to break the
  // in_ready/flush_active loop; a flush that cannot drain stalls the beat too.
  always_comb begin
    slot_free    = !out_valid || out_ready;
    is_final     = (cnt == LAST);
    flush_req    = flush && ((cnt != '0) || in_valid);
    in_ready     = !(is_final && !slot_free) && !(flush_req && !slot_free);
    accept       = in_valid && in_ready;
    flush_active = flush && ((cnt != '0) || accept);
  end
`else
  logic unused_flush;
  assign unused_flush = flush;

  always_comb begin
    slot_free    = !out_valid || out_ready;
    is_final     = (cnt == LAST);
    in_ready     = !(is_final && !slot_free);
    accept       = in_valid && in_ready;
    flush_active = 1'b0;
  end
`endif

  always_comb begin
    slot       = msb_first ? (LAST - cnt) : cnt;
    merged     = acc;
    for (int k = 0; k < beats; k++) begin
      if (accept && (slot == CW'(k))) merged[k*in_width +: in_width] = in_data;
    end
    load_full  = accept && is_final;
    load_flush = flush_active && slot_free && !load_full;
  end

  // A loading word overrides the drain, so back-to-back words have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load_full || load_flush) begin
      out_data  <= merged;
      out_valid <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      if (accept) begin
        acc <= merged;
        cnt <= cnt + 1'b1;
      end
      if (out_ready) out_valid <= 1'b0;
    end
  end

`ifdef SERIAL_TO_PARALLEL_STREAM_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      beats_q <= '0;
    end else if (load_full) begin
      beats_q <= BW'(beats);
    end else if (load_flush) begin
      beats_q <= BW'(cnt) + BW'(accept);
    end
  end

  assign out_beats = beats_q;
`else
  assign out_beats = BW'(beats);
`endif

endmodule
